// File: rtl/alu32_pkg.sv
// Shared FSM state codes and ALU function codes for the ALU32 issue unit.
// Function codes are packed as {M, S}.
package alu32_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef logic [4:0] alu_op_t;

  // M=1 selects the adder path, M=0 the bitwise logic path.
  localparam alu_op_t ALU_PASS = {1'b0, 4'h0};
  localparam alu_op_t ALU_ADD  = {1'b1, 4'b1001};
  localparam alu_op_t ALU_SUB  = {1'b1, 4'b0110};
  localparam alu_op_t ALU_INC  = {1'b1, 4'b0000};
  localparam alu_op_t ALU_DEC  = {1'b1, 4'b1111};

endpackage

// File: rtl/alu32_issue_unit_alu32.sv
// Combinational ALU32 datapath: adder path computes a + y + cin with y chosen
// by S; logic path applies a bitwise function of a and b.
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic [WIDTH-1:0] dout,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             z
);
  import alu32_pkg::*;

  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] lres;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    y    = b;
    lres = '0;
    dout = '0;
    c    = 1'b0;
    v    = 1'b0;

    case ({m, s})
      ALU_SUB: y = ~b;
      ALU_INC: y = '0;
      ALU_DEC: y = '1;
      default: y = b;
    endcase
    sum = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    case ({1'b0, s})
      ALU_PASS: lres = a;
      5'h01:    lres = b;
      5'h02:    lres = a & b;
      5'h03:    lres = a | b;
      5'h04:    lres = a ^ b;
      5'h05:    lres = ~a;
      5'h06:    lres = ~(a & b);
      5'h07:    lres = ~(a | b);
      5'h08:    lres = ~(a ^ b);
      5'h09:    lres = a & ~b;
      5'h0a:    lres = a | ~b;
      5'h0b:    lres = ~b;
      5'h0c:    lres = '1;
      default:  lres = '0;
    endcase

    if (m) begin
      dout = sum[WIDTH-1:0];
      c    = sum[WIDTH];
      // Signed overflow: both addends share a sign the result does not.
      v    = (a[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      dout = lres;
    end
  end

  assign n = dout[WIDTH-1];
  assign z = (dout == '0);

endmodule

// File: rtl/alu32_issue_unit.sv
// Valid/ready command front-end around ALU32: registers a command, executes
// it for one cycle, and holds the result until the consumer takes it.
module alu32_issue_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_s,
  input  logic             cmd_m,
  input  logic             cmd_cin,
  input  logic             cmd_chain,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             clr_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_do,
  output logic             rsp_n,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic             rsp_z,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] op_count
);
  import alu32_pkg::*;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             cin_q;
  logic [TAG_W-1:0] tag_q;
  logic             carry_q;

  logic [WIDTH-1:0] alu_do;
  logic             alu_n;
  logic             alu_c;
  logic             alu_v;
  logic             alu_z;
  logic             accept;

  // A held response frees the unit in the same cycle it is consumed.
  assign cmd_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  // Valid only while a result is held, so a consumed result is never shown
  // again during the EXEC cycle of a back-to-back command.
  assign rsp_valid = (state == RESP);

  alu32 #(.WIDTH(WIDTH)) u_alu32 (
    .a    (a_q),
    .b    (b_q),
    .s    (s_q),
    .m    (m_q),
    .cin  (cin_q),
    .dout (alu_do),
    .n    (alu_n),
    .c    (alu_c),
    .v    (alu_v),
    .z    (alu_z)
  );

  // NOTE: operand registers carry no reset; they are only consumed after an
  // accept has loaded them, so resetting them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= cmd_a;
      b_q   <= cmd_b;
      s_q   <= cmd_s;
      m_q   <= cmd_m;
      tag_q <= cmd_tag;
      cin_q <= cmd_chain ? carry_q : cmd_cin;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, e.g. a chained accept sees carry_q before clr_carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rsp_do   <= '0;
      rsp_n    <= 1'b0;
      rsp_c    <= 1'b0;
      rsp_v    <= 1'b0;
      rsp_z    <= 1'b0;
      rsp_tag  <= '0;
      carry_q  <= 1'b0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_do  <= alu_do;
          rsp_n   <= alu_n;
          rsp_c   <= alu_c;
          rsp_v   <= alu_v;
          rsp_z   <= alu_z;
          rsp_tag <= tag_q;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
            state <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A clear on the capture edge wins over the new ALU carry.
      if (clr_carry)           carry_q <= 1'b0;
      else if (state == EXEC)  carry_q <= alu_c;
    end
  end

endmodule
